// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared OFDM transmitter constants and the symbol scheduler state type.
package ofdm_pkg;
    localparam int N_SC     = 48;
    localparam int SC_IDX_W = 6;
    typedef enum logic [2:0] {IDLE, SIG, GAP, DATA, DONE} sched_state_t;
endpackage

// File: rtl/sc_counter.sv
// sc_counter: subcarrier index counter that wraps at N and flags the last index.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : synchronous clear back to index 0
//   en_i       : advance by one (wraps N-1 -> 0)
//   cnt_o      : current subcarrier index
//   cnt_last_o : high while cnt_o == N-1
module sc_counter
    import ofdm_pkg::*;
#(
    parameter int N = N_SC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    output logic [SC_IDX_W-1:0] cnt_o,
    output logic                cnt_last_o
);
    logic [SC_IDX_W-1:0] cnt_q, cnt_d;
    assign cnt_last_o = cnt_q == SC_IDX_W'(N - 1);
    assign cnt_d      = clr_i ? '0 : !en_i ? cnt_q : cnt_last_o ? '0 : cnt_q + 1'b1;
    assign cnt_o      = cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pilot_sched.sv
// pilot_sched: frames one SIGNAL symbol then n_sym DATA symbols toward the pilot stage.
//   clk, rst           : clock, synchronous active-high reset
//   start, n_sym       : frame start pulse (IDLE only) and DATA symbol count
//   busy, frame_done   : frame in progress, one-cycle end-of-frame pulse
//   sig_din*           : SIGNAL source stream (data/vld/rdy)
//   data_din*          : DATA source stream (data/vld/rdy)
//   sched_dout*        : tagged sample stream to the pilot stage (data/index/sym/vld/rdy/last)
module pilot_sched
    import ofdm_pkg::*;
#(
    parameter int DW      = 16,
    parameter int N_SC    = ofdm_pkg::N_SC,
    parameter int SYM_W   = 10,
    parameter int GAP_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SYM_W-1:0]    n_sym,
    output logic                busy,
    output logic                frame_done,
    input  logic [DW-1:0]       sig_din,
    input  logic                sig_din_vld,
    output logic                sig_din_rdy,
    input  logic [DW-1:0]       data_din,
    input  logic                data_din_vld,
    output logic                data_din_rdy,
    output logic [DW-1:0]       sched_dout,
    output logic [5:0]          sched_dout_index,
    output logic [SYM_W:0]      sched_dout_sym,
    output logic                sched_dout_vld,
    input  logic                sched_dout_rdy,
    output logic                sched_dout_last
);
    localparam int GW = $clog2(GAP_CYC + 1);
    sched_state_t        state_q, state_d;
    logic [SYM_W-1:0]    n_sym_l_q, n_sym_l_d;
    logic [SYM_W:0]      sym_cnt_q, sym_cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                accept, xfer, sc_last, gap_done, sel_sig, sel_data;
    logic [SC_IDX_W-1:0] sc_cnt;
    assign accept   = state_q == IDLE && start;
    assign xfer     = sched_dout_vld && sched_dout_rdy;
    assign gap_done = gap_q == GW'(GAP_CYC - 1);
    sc_counter #(.N(N_SC)) u_sc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .en_i       (xfer),
        .cnt_o      (sc_cnt),
        .cnt_last_o (sc_last)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = SIG;
            SIG, DATA: if (xfer && sc_last) state_d = GAP;
            GAP:       if (gap_done) state_d = (sym_cnt_q < {1'b0, n_sym_l_q}) ? DATA : DONE;
            default:   state_d = IDLE;
        endcase
    end
    // sym_cnt advances on entry to DATA so it reads k throughout the k-th DATA symbol.
    assign n_sym_l_d = accept ? n_sym : n_sym_l_q;
    assign sym_cnt_d = accept ? '0 : (state_q == GAP && state_d == DATA) ? sym_cnt_q + 1'b1 : sym_cnt_q;
    assign gap_d     = (state_q == GAP && !gap_done) ? gap_q + 1'b1 : '0;
    assign busy_d    = state_d != IDLE;
    assign done_d    = state_d == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            n_sym_l_q <= '0;
            sym_cnt_q <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            n_sym_l_q <= n_sym_l_d;
            sym_cnt_q <= sym_cnt_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    always_comb begin
        sel_sig         = state_q == SIG;
        sel_data        = state_q == DATA;
        sched_dout      = sel_data ? data_din : sig_din;
        sched_dout_vld  = sel_sig ? sig_din_vld : sel_data ? data_din_vld : 1'b0;
        sig_din_rdy     = sel_sig && sched_dout_rdy;
        data_din_rdy    = sel_data && sched_dout_rdy;
        sched_dout_last = sched_dout_vld && sc_last &&
                          ((sel_sig && n_sym_l_q == '0) || (sel_data && sym_cnt_q == {1'b0, n_sym_l_q}));
    end
    assign sched_dout_index = sc_cnt;
    assign sched_dout_sym   = sym_cnt_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;
endmodule

// File: tb/tb_pilot_sched.sv
// tb_pilot_sched: scoreboard bench for the pilot symbol scheduler.
module tb_pilot_sched;
    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  idx;
        logic [10:0] sym;
        logic        last;
    } exp_t;
    logic        clk = 0, rst = 1, start = 0;
    logic [9:0]  n_sym = 0;
    logic        busy, frame_done;
    logic [15:0] sig_din = 0, data_din = 0, sched_dout;
    logic        sig_din_vld = 0, sig_din_rdy, data_din_vld = 0, data_din_rdy;
    logic [5:0]  sched_dout_index;
    logic [10:0] sched_dout_sym;
    logic        sched_dout_vld, sched_dout_rdy = 0, sched_dout_last;
    exp_t        exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          sig_ptr = 0, data_ptr = 0;
    int          busy_cnt, fd_cnt, idle_cnt, data_rdy_seen;
    bit          rnd = 0;
    pilot_sched #(.DW(16), .N_SC(48), .SYM_W(10), .GAP_CYC(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .n_sym            (n_sym),
        .busy             (busy),
        .frame_done       (frame_done),
        .sig_din          (sig_din),
        .sig_din_vld      (sig_din_vld),
        .sig_din_rdy      (sig_din_rdy),
        .data_din         (data_din),
        .data_din_vld     (data_din_vld),
        .data_din_rdy     (data_din_rdy),
        .sched_dout       (sched_dout),
        .sched_dout_index (sched_dout_index),
        .sched_dout_sym   (sched_dout_sym),
        .sched_dout_vld   (sched_dout_vld),
        .sched_dout_rdy   (sched_dout_rdy),
        .sched_dout_last  (sched_dout_last)
    );
    initial forever #5 clk = ~clk;
    initial begin
        bit sf, df;
        forever begin
            @(negedge clk);
            sf = sig_din_vld && sig_din_rdy;
            df = data_din_vld && data_din_rdy;
            @(posedge clk);
            #1;
            if (sf) sig_ptr++;
            if (df) data_ptr++;
            sig_din        = 16'h8000 | 16'(sig_ptr & 'h7fff);
            data_din       = 16'(data_ptr);
            sig_din_vld    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_din_vld   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            sched_dout_rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end
    initial begin
        exp_t g, e;
        forever begin
            @(negedge clk);
            busy_cnt += int'(busy);
            fd_cnt   += int'(frame_done);
            idle_cnt += int'(busy && !sched_dout_vld);
            if (data_din_rdy) data_rdy_seen = 1;
            if (sched_dout_vld && sched_dout_rdy) begin
                g = '{sched_dout, sched_dout_index, sched_dout_sym, sched_dout_last};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL xfer: unexpected transfer d=%h idx=%0d sym=%0d last=%0b, none required", g.d, g.idx, g.sym, g.last);
                end else begin
                    e = exp_q.pop_front();
                    if (g != e) begin
                        miscompares++;
                        $display("FAIL xfer: got d=%h idx=%0d sym=%0d last=%0b, required d=%h idx=%0d sym=%0d last=%0b",
                                 g.d, g.idx, g.sym, g.last, e.d, e.idx, e.sym, e.last);
                    end
                end
            end
        end
    end
    task automatic chk(input string nm, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic clr_stats();
        busy_cnt = 0;
        fd_cnt = 0;
        idle_cnt = 0;
        data_rdy_seen = 0;
    endtask
    task automatic run(input int n);
        exp_t e;
        clr_stats();
        for (int s = 0; s <= n; s++)
            for (int i = 0; i < 48; i++) begin
                e.d    = (s == 0) ? (16'h8000 | 16'((sig_ptr + i) & 'h7fff)) : 16'(data_ptr + (s - 1) * 48 + i);
                e.idx  = 6'(i);
                e.sym  = 11'(s);
                e.last = (s == n && i == 47);
                exp_q.push_back(e);
            end
        start = 1;
        n_sym = 10'(n);
        cyc(1);
        start = 0;
    endtask
    task automatic wait_done(input string nm, input int lim);
        int k = 0;
        while (!frame_done && k < lim) begin
            cyc(1);
            k++;
        end
        vectors++;
        if (!frame_done) begin
            miscompares++;
            $display("FAIL %s: frame_done not seen within %0d cycles", nm, lim);
        end
        cyc(4);
        chk({nm, "_drain"}, exp_q.size(), 0);
        chk({nm, "_fd_pulses"}, fd_cnt, 1);
    endtask
    task automatic wait_for(input string nm, input int sym, input int idx);
        int k = 0;
        while (!(sched_dout_vld && sched_dout_sym == 11'(sym) && sched_dout_index == 6'(idx)) && k < 1000) begin
            cyc(1);
            k++;
        end
        chk({nm, "_reached"}, int'(sched_dout_vld && sched_dout_sym == 11'(sym) && sched_dout_index == 6'(idx)), 1);
    endtask
    initial begin
        cyc(3);
        rst = 0;
        cyc(1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_vld", sched_dout_vld, 0);
        chk("rst_sig_rdy", sig_din_rdy, 0);
        chk("rst_data_rdy", data_din_rdy, 0);
        chk("rst_index", sched_dout_index, 0);
        chk("rst_sym", sched_dout_sym, 0);
        run(2);
        wait_done("n2", 400);
        chk("n2_busy_cycles", busy_cnt, 151);
        chk("n2_idle_busy_cycles", idle_cnt, 7);
        run(0);
        wait_done("n0", 200);
        chk("n0_data_rdy_seen", data_rdy_seen, 0);
        chk("n0_busy_cycles", busy_cnt, 51);
        rnd = 1;
        run(3);
        wait_done("rand_n3", 3000);
        rnd = 0;
        cyc(2);
        run(1);
        wait_for("ign", 1, 5);
        start = 1;
        n_sym = 10'd5;
        cyc(1);
        start = 0;
        wait_done("ign", 400);
        chk("ign_busy_cycles", busy_cnt, 101);
        cyc(20);
        chk("ign_busy_after", busy, 0);
        run(1);
        wait_for("rst", 1, 20);
        rst = 1;
        cyc(1);
        chk("rst_mid_vld", sched_dout_vld, 0);
        chk("rst_mid_sig_rdy", sig_din_rdy, 0);
        chk("rst_mid_data_rdy", data_din_rdy, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_index", sched_dout_index, 0);
        rst = 0;
        exp_q.delete();
        cyc(2);
        run(1);
        wait_done("post_rst", 400);
        run(1023);
        wait_done("n1023", 60000);
        chk("n1023_busy_cycles", busy_cnt, 1024 * 50 + 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
